// File: rtl/spi_minion_modes_pkg.sv
// Shared types and sizing helpers for the SPI minion.
package spi_minion_modes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // The bit counter must hold the value NBITS itself, hence the +1.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a delayed copy, giving single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            dly  <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/spi_minion_modes.sv
// SPI minion for all four CPOL/CPHA modes, oversampled by the system clock.
module spi_minion_modes
    import spi_minion_modes_pkg::*;
#(
    parameter int unsigned NBITS = 8,
    parameter bit          CPOL  = 1'b0,
    parameter bit          CPHA  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             push_val,
    input  logic             push_rdy,
    output logic [NBITS-1:0] push_msg,
    input  logic             pull_val,
    output logic             pull_rdy,
    input  logic [NBITS-1:0] pull_msg,
    output logic             overflow,
    output logic             frame_err,
    output logic             underrun
);

    localparam int             CW   = cnt_width(NBITS);
    localparam logic [CW-1:0]  LAST = CW'(NBITS - 1);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk (clk), .reset (reset), .d (cs),
        .q (cs_s), .rise (cs_rise), .fall (cs_fall)
    );

    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk (clk), .reset (reset), .d (sclk),
        .q (sclk_s), .rise (sclk_rise), .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .reset (reset), .d (mosi),
        .q (mosi_s), .rise (), .fall ()
    );

    // Leading edge leaves the idle level; trailing edge returns to it.
    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;

    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_s != CPOL);
    assign trail_edge  = sclk_edge & (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [NBITS-1:0]  rx_q, tx_q, hold_q;
    logic              first_q, push_val_q, ovf_q, ferr_q, urun_q;
    logic              start, do_sample, do_shift, deliver, abort;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pull_rdy  = 1'b0;
        start     = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        deliver   = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d  = ST_SHIFT;
                    pull_rdy = 1'b1;
                    start    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (!cs_s) begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                    if (sample_edge && cnt_q == LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    deliver = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: all datapath registers are reset so a frame cut by reset leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            first_q <= 1'b0;
            ferr_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            ferr_q <= abort;
            urun_q <= start & ~pull_val;
            if (start) begin
                cnt_q   <= '0;
                tx_q    <= pull_val ? pull_msg : '0;
                first_q <= CPHA;
            end
            if (do_sample) begin
                rx_q  <= {rx_q[NBITS-2:0], mosi_s};
                cnt_q <= cnt_q + 1'b1;
            end
            // In CPHA=1 the first leading edge precedes any sample, so the MSB must stay put.
            if (do_shift) begin
                if (first_q) first_q <= 1'b0;
                else         tx_q    <= {tx_q[NBITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q     <= '0;
            push_val_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (deliver) begin
                if (push_val_q && !push_rdy) begin
                    ovf_q <= 1'b1;
                end else begin
                    hold_q     <= rx_q;
                    push_val_q <= 1'b1;
                end
            end else if (push_val_q && push_rdy) begin
                push_val_q <= 1'b0;
            end
        end
    end

    assign miso      = (state_q != ST_IDLE) & tx_q[NBITS-1];
    assign push_val  = push_val_q;
    assign push_msg  = hold_q;
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;
    assign underrun  = urun_q;

endmodule
